// File: rtl/lane_key_capture.sv
// lane_key_capture
//   Turns four raw lane buttons into clean, timestamped press events and
//   queues them for the hit-judge logic.
//
//   Per lane: 2-flop synchroniser -> counter debouncer -> rising-edge detect
//   -> one-deep pending slot holding the press timestamp. A fixed-priority
//   arbiter (lowest lane first) moves at most one pending press per cycle
//   into a first-word-fall-through FIFO read through a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   btnl/btnu/btnd/btnr      raw async buttons, lanes 0..3
//   tick                     one-cycle strobe advancing the timestamp
//   ev_valid/ev_ready        FIFO head handshake (pop on valid & ready)
//   ev_lane, ev_time         head event contents (0 while empty)
//   lane_level               debounced button levels, bit i = lane i
//   overflow                 sticky: a press was dropped

// Per-lane front end: synchroniser, debouncer, press detect and the
// pending slot that waits for the arbiter.
module lane_key_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TS_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic [TS_W-1:0] ts,
  input  logic            grant,
  output logic            stable,
  output logic            pend,
  output logic [TS_W-1:0] ptime,
  output logic            lost
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  // sync_pipe[1] is the synchronised level
  logic [1:0]       sync_pipe;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             press;

  assign flip  = (sync_pipe[1] != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press = flip && sync_pipe[1];
  // A press while the slot is occupied is dropped, even when the slot is
  // being drained this very cycle: the older timestamp is the one kept.
  assign lost  = press && pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      cnt       <= '0;
      stable    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      if (sync_pipe[1] == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync_pipe[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 1'b0;
      ptime <= '0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (press && !pend) begin
      pend  <= 1'b1;
      ptime <= ts;
    end
  end
endmodule

module lane_key_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TS_W            = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnl,
  input  logic            btnu,
  input  logic            btnd,
  input  logic            btnr,
  input  logic            tick,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [1:0]      ev_lane,
  output logic [TS_W-1:0] ev_time,
  output logic [3:0]      lane_level,
  output logic            overflow
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [TS_W-1:0]   t;
  } ev_t;

  logic [NUM_LANES-1:0]           raw;
  logic [NUM_LANES-1:0]           stable;
  logic [NUM_LANES-1:0]           pend;
  logic [NUM_LANES-1:0]           lost;
  logic [NUM_LANES-1:0]           grant;
  logic [NUM_LANES-1:0][TS_W-1:0] ptime;
  logic [TS_W-1:0]                ts;

  ev_t               mem [FIFO_DEPTH];
  ev_t               head;
  ev_t               wr_ev;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CW-1:0]     count;
  logic              wr_en, pop;
  logic [LANE_W-1:0] wr_lane;

  assign raw = {btnr, btnd, btnu, btnl};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_key_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .TS_W            (TS_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[i]),
      .ts     (ts),
      .grant  (grant[i]),
      .stable (stable[i]),
      .pend   (pend[i]),
      .ptime  (ptime[i]),
      .lost   (lost[i])
    );
  end

  // Fullness uses the registered count, so a same-cycle pop never makes
  // room for a write.
  assign wr_en = (|pend) && (count < CW'(FIFO_DEPTH));
  // Lowest set pending bit wins.
  assign grant = wr_en ? (pend & (~pend + NUM_LANES'(1))) : '0;

  always_comb begin
    wr_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (pend[i]) wr_lane = LANE_W'(i);
  end

  assign wr_ev = '{lane: wr_lane, t: ptime[wr_lane]};

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else if (tick) ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (|lost) overflow <= 1'b1;
  end

  // Storage is not reset: entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= (wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      if (pop)   rptr <= (rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rptr];
  assign ev_valid   = (count != '0);
  assign pop        = ev_valid && ev_ready;
  // Gate the head so every output reads 0 out of reset / while empty.
  assign ev_lane    = ev_valid ? head.lane : '0;
  assign ev_time    = ev_valid ? head.t    : '0;
  assign lane_level = stable;
endmodule

// File: tb/tb_lane_key_capture.sv
module tb_lane_key_capture;
  localparam int DC    = 4;
  localparam int TSW   = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     btn;
  logic           tick;
  logic           ev_ready;
  logic           ev_valid;
  logic [1:0]     ev_lane;
  logic [TSW-1:0] ev_time;
  logic [3:0]     lane_level;
  logic           overflow;

  lane_key_capture #(.DEBOUNCE_CYCLES(DC), .TS_W(TSW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .btnl       (btn[0]),
    .btnu       (btn[1]),
    .btnd       (btn[2]),
    .btnr       (btn[3]),
    .tick       (tick),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_lane    (ev_lane),
    .ev_time    (ev_time),
    .lane_level (lane_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0]     lane;
    logic [TSW-1:0] t;
  } mev_t;

  mev_t           m_q[$];
  bit [3:0]       m_d1, m_d2, m_stable, m_pend, m_old_pend, m_rise;
  int             m_run[4];          // consecutive cycles synced level != stable
  bit [TSW-1:0]   m_ptime[4];
  bit [TSW-1:0]   m_ts;
  bit             m_ovf;
  int             m_wl;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_pend = '0; m_ovf = 1'b0; m_ts = '0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_ptime[i] = '0; end
    end else begin
      m_old_pend = m_pend;
      m_rise     = '0;
      m_wl       = -1;
      if (m_q.size() < DEPTH)
        for (int i = 3; i >= 0; i--) if (m_old_pend[i]) m_wl = i;
      for (int i = 0; i < 4; i++) begin
        if (m_d2[i] == m_stable[i]) m_run[i] = 0;
        else if (m_run[i] == DC - 1) begin
          m_stable[i] = m_d2[i];
          m_run[i]    = 0;
          m_rise[i]   = m_d2[i];
        end else m_run[i]++;
      end
      if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
      if (m_wl >= 0) begin
        m_q.push_back('{lane: 2'(m_wl), t: m_ptime[m_wl]});
        m_pend[m_wl] = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (m_rise[i]) begin
          if (m_old_pend[i]) m_ovf = 1'b1;
          else begin m_pend[i] = 1'b1; m_ptime[i] = m_ts; end
        end
      m_d2 = m_d1;
      m_d1 = btn;
      if (tick) m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(ev_valid), 32'(m_q.size() != 0));
      chk("m_lane",  32'(ev_lane),  (m_q.size() != 0) ? 32'(m_q[0].lane) : 32'd0);
      chk("m_time",  32'(ev_time),  (m_q.size() != 0) ? 32'(m_q[0].t)    : 32'd0);
      chk("m_level", 32'(lane_level), 32'(m_stable));
      chk("m_ovf",   32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from the first edge seeing current inputs until ev_valid.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ev_valid) break;
    end
    if (!ev_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  int n, bad;

  initial begin
    rst = 1'b1; btn = '0; tick = 1'b0; ev_ready = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;

    // reset with toggling buttons
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      btn = (c % 2 == 0) ? 4'hF : 4'h5;
      tick = 1'b1;
    end
    @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_level", 32'(lane_level), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    btn = '0; tick = 1'b0; rst = 1'b0;
    cyc(10);

    // clean press: ts=5, btnu held 20 cycles
    tick = 1'b1; cyc(5); tick = 1'b0;
    ev_ready = 1'b1;
    btn[1] = 1'b1;
    wait_valid("press", n);
    chk("press_latency", 32'(n - 1), 32'd6);
    chk("press_lane", 32'(ev_lane), 32'd1);
    chk("press_time", 32'(ev_time), 32'd5);
    bad = 0;
    for (int c = 0; c < 20 - n; c++) begin @(negedge clk); if (ev_valid) bad++; end
    chk("press_single", 32'(bad), 32'd0);
    btn[1] = 1'b0;
    cyc(5);
    chk("release_hold", 32'(lane_level[1]), 32'd1);
    cyc(1);
    chk("release_drop", 32'(lane_level[1]), 32'd0);
    cyc(4);

    // bounce: 3 high, 1 low, 2 high
    btn[0] = 1'b1; cyc(3); btn[0] = 1'b0; cyc(1); btn[0] = 1'b1; cyc(2); btn[0] = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (ev_valid || lane_level[0]) bad++; end
    chk("bounce_none", 32'(bad), 32'd0);

    // simultaneous press at ts=9
    tick = 1'b1; cyc(4); tick = 1'b0;
    btn = 4'b1001;
    wait_valid("simul", n);
    chk("simul_lane0", 32'(ev_lane), 32'd0);
    chk("simul_time0", 32'(ev_time), 32'd9);
    @(negedge clk);
    chk("simul_valid3", 32'(ev_valid), 32'd1);
    chk("simul_lane3", 32'(ev_lane), 32'd3);
    chk("simul_time3", 32'(ev_time), 32'd9);
    @(negedge clk);
    chk("simul_empty", 32'(ev_valid), 32'd0);
    btn = '0; cyc(10);

    // full FIFO then loss
    ev_ready = 1'b0;
    btn = 4'hF; cyc(8); btn = '0; cyc(10);
    tick = 1'b1; cyc(3); tick = 1'b0;
    btn[0] = 1'b1; cyc(8); btn[0] = 1'b0; cyc(8);
    chk("full_ovf0", 32'(overflow), 32'd0);
    chk("full_head", 32'(ev_lane), 32'd0);
    btn[0] = 1'b1; cyc(8); btn[0] = 1'b0; cyc(8);
    chk("full_ovf1", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin if (ev_valid) n++; @(negedge clk); end
    chk("drain_count", 32'(n), 32'd5);
    chk("drain_ovf", 32'(overflow), 32'd1);

    // timestamp wrap
    rst = 1'b1; cyc(1); rst = 1'b0;
    tick = 1'b1; cyc(256); tick = 1'b0;
    btn[2] = 1'b1;
    wait_valid("wrap", n);
    chk("wrap_lane", 32'(ev_lane), 32'd2);
    chk("wrap_time", 32'(ev_time), 32'd0);
    btn = '0; cyc(10);

    // mid-operation reset with two events queued
    ev_ready = 1'b0;
    btn = 4'b0011; cyc(10); btn = '0; cyc(10);
    chk("mid_queued", 32'(ev_valid), 32'd1);
    rst = 1'b1; cyc(1);
    chk("mid_cleared", 32'(ev_valid), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (ev_valid) bad++; end
    chk("mid_nothing", 32'(bad), 32'd0);

    // random phase: long-ish holds mixed with bounces
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 6) == 0) btn[i] = ~btn[i];
      tick     = ($urandom_range(0, 3) == 0);
      ev_ready = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_key_capture.md
# lane_key_capture

Input-side capture block for the rhythm game: takes the four raw lane buttons (btnl, btnu, btnd, btnr) and turns them into clean, timestamped press events. Each button is synchronised, debounced and rising-edge detected, then queued in a small FIFO. The scoring logic reads the FIFO through a valid/ready handshake. The block sits between the board pins and the hit-judge logic inside `top`.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synced level must differ from the stable level before the stable level flips (10 ms at 100 MHz); must be ≥ 2.
- TS_W, 16: timestamp width.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two.
- clk  in  1  system clock. One clock domain; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- btnl, btnu, btnd, btnr  in  1 each  raw asynchronous lane buttons, mapped to lanes 0, 1, 2, 3.
- tick  in  1  one-cycle strobe that advances the timestamp.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_lane  out  2  lane index of the head event.
- ev_time  out  TS_W  timestamp of the head event.
- lane_level  out  4  debounced button levels; bit i = lane i.
- overflow  out  1  sticky flag: a press event was lost.

## Operation
- Reset value of every output is 0. Reset also clears the sync flops, debounce counters, stable levels, pending flags, FIFO pointers and count, the timestamp, and overflow. Any in-flight event is discarded.
- **Synchroniser:** two flops per button.
- **Debounce (per lane):**
  - Counter cnt clears whenever sync == stable.
  - Otherwise cnt increments.
  - When sync != stable and cnt == DEBOUNCE_CYCLES-1, stable <= sync and cnt <= 0.
  - lane_level = stable.
- **Press detect:** the edge where stable goes 0→1 is a press.
  - On that edge, pending[i] <= 1 and ptime[i] <= ts (the timestamp value before that edge's update).
  - Releases generate nothing.
- **Timestamp:** ts increments on each tick and wraps modulo 2^TS_W.
- **Arbiter:**
  - Each cycle, if any pending bit is set and the FIFO count < FIFO_DEPTH, the lowest-index pending lane is written as {lane, ptime} and its pending bit clears.
  - At most one write per cycle.
  - The full check uses the registered count. A pop in the same cycle does not free a slot for that cycle's write.
- **Lost event:** a press on lane i while pending[i] is already set sets overflow. The older ptime is kept and the new press is dropped. The same rule applies when the pending bit is being cleared by a write in that same cycle: the pend-clear wins and the new press is lost.
- **FIFO:**
  - First-word-fall-through.
  - ev_valid = (count != 0); ev_lane and ev_time show the head entry.
  - Pop on ev_valid & ev_ready.
  - Push and pop in the same cycle leave count unchanged.
  - ev_ready while ev_valid = 0 is ignored.
- overflow stays at 1 until rst.

## Timing
- Raw button high before edge k, then:
  - sync high after edge k+1;
  - stable and pending high after edge k+1+DEBOUNCE_CYCLES;
  - FIFO write at edge k+2+DEBOUNCE_CYCLES;
  - ev_valid high in the following cycle.
- Raw-to-ev_valid latency is therefore DEBOUNCE_CYCLES+2 edges, provided the FIFO is not full and no lower lane is pending.
- Simultaneous presses on n lanes drain as n consecutive writes in lane order, all with identical ev_time.
- Throughput: one event per cycle in and out.
- A head popped at edge e shows the next entry after edge e.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TS_W=8, FIFO_DEPTH=4.
- **Reset:** hold rst 3 cycles with buttons toggling → all outputs 0, then no event until a full debounce completes.
- **Clean press:** issue 5 ticks, then btnu held for 20 cycles, ev_ready=1 → exactly one event, lane=1, time=5. ev_valid rises 6 edges after raw; lane_level[1]=1 until 4+2 cycles after release.
- **Bounce:** btnl high for 3 cycles, low, high for 2 cycles → no event; lane_level stays 0.
- **Simultaneous press:** btnl and btnr pressed on the same edge at ts=9 → events (lane 0, 9) then (lane 3, 9) on consecutive cycles.
- **Full FIFO and loss:**
  - With ev_ready=0, press all four lanes, release, then press btnl again → FIFO holds 4 events, pending[0] set, overflow=0.
  - A further debounced btnl press → overflow=1.
  - Then assert ev_ready → 5 events drain; overflow stays 1.
- **Wrap and mid-op reset:**
  - 256 ticks → ts back to 0; a press then reports time=0.
  - rst asserted with 2 events queued → ev_valid=0 on the next cycle, and nothing reappears.
